nco_sweep_ctrl: RTL

NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

---
 rtl/nco_ctrl_pkg.sv | 16 +
 rtl/nco_dwell_timer.sv | 33 +++
 rtl/nco_sweep_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/nco_ctrl_pkg.sv
// Shared definitions for the NCO sweep controller: state encoding and default widths.
package nco_ctrl_pkg;

  // Default phase-increment width, matching the NCO phase accumulator.
  localparam int unsigned NcoPwDefault = 19;
  // Default dwell-counter width.
  localparam int unsigned NcoDwDefault = 16;

  // Sweep controller states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDwell = 2'd1,
    StFin   = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/nco_dwell_timer.sv
// Dwell timer: loadable down-counter that stops at zero and flags it.
module nco_dwell_timer
  import nco_ctrl_pkg::*;
#(
  parameter int unsigned DW = NcoDwDefault
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] load_val,
  output logic          zero
);

  logic [DW-1:0] cnt_q;

  // Load has priority; otherwise count down while enabled, parking at zero.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Zero flag drives the step decision in the controller.
  always_comb begin
    zero = (cnt_q == '0);
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// NCO frequency sweep controller. Steps phase_inc from a start to a stop increment,
// holding each value for cfg_dwell+1 cycles, in single-shot or repeating mode.
// Optional build macro NCO_SWEEP_TRIANGLE_EN: in continuous mode the sweep runs up and
// back down (triangle) instead of jumping back to start (sawtooth).
module nco_sweep_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int unsigned PW = NcoPwDefault,
  parameter int unsigned DW = NcoDwDefault
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic [PW-1:0] cfg_start_inc,
  input  logic [PW-1:0] cfg_stop_inc,
  input  logic [PW-1:0] cfg_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic          cfg_continuous,
  input  logic          start,
  input  logic          abort,
  output logic [PW-1:0] phase_inc,
  output logic          busy,
  output logic          step_strobe,
  output logic          done
);

  sweep_state_e state_q, state_d;

  logic [PW-1:0] phase_q, phase_d;
  logic          strobe_q, strobe_d;

  // Shadow copies of the configuration, captured on an accepted start.
  logic [PW-1:0] start_q, stop_q, step_q;
  logic [DW-1:0] dwell_q;
  logic          cont_q;
  logic          shadow_load;

  logic          timer_load, timer_en, timer_zero;
  logic [DW-1:0] timer_val;

  logic [PW:0]   up_sum;
  logic [PW-1:0] up_next;
  logic          degenerate, at_stop, sweep_end;

`ifdef NCO_SWEEP_TRIANGLE_EN
  logic          dir_q, dir_d;  // 0 = sweeping up, 1 = sweeping down
  logic [PW-1:0] dn_diff, dn_next;
  logic          at_start;
`endif

  nco_dwell_timer #(
    .DW (DW)
  ) u_dwell_timer (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .en       (timer_en),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // Step arithmetic: upward step saturates at stop, computed one bit wider so it never wraps.
  always_comb begin
    up_sum     = {1'b0, phase_q} + {1'b0, step_q};
    up_next    = (up_sum >= {1'b0, stop_q}) ? stop_q : up_sum[PW-1:0];
    degenerate = (step_q == '0) || (start_q > stop_q);
    at_stop    = (phase_q == stop_q);
    sweep_end  = at_stop || degenerate;
`ifdef NCO_SWEEP_TRIANGLE_EN
    // Non-degenerate sweeps keep phase_q >= start_q, so the difference cannot underflow.
    at_start = (phase_q == start_q);
    dn_diff  = phase_q - start_q;
    dn_next  = (dn_diff <= step_q) ? start_q : (phase_q - step_q);
`endif
  end

  // State register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath next-value logic.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    strobe_d    = 1'b0;
    shadow_load = 1'b0;
    timer_load  = 1'b0;
    timer_en    = 1'b0;
    timer_val   = dwell_q;
`ifdef NCO_SWEEP_TRIANGLE_EN
    dir_d       = dir_q;
`endif
    unique case (state_q)
      StIdle: begin
        // Abort wins over a coincident start.
        if (start && !abort) begin
          shadow_load = 1'b1;
          phase_d     = cfg_start_inc;
          strobe_d    = 1'b1;
          timer_load  = 1'b1;
          timer_val   = cfg_dwell;
          state_d     = StDwell;
`ifdef NCO_SWEEP_TRIANGLE_EN
          dir_d       = 1'b0;
`endif
        end
      end
      StDwell: begin
        if (abort) begin
          state_d = StIdle;
        end else if (!timer_zero) begin
          timer_en = 1'b1;
        end else begin
`ifdef NCO_SWEEP_TRIANGLE_EN
          if (cont_q && !degenerate) begin
            // Turn around at either end; each end value is held for a single dwell.
            if (dir_q) begin
              if (at_start) begin
                dir_d   = 1'b0;
                phase_d = up_next;
              end else begin
                phase_d = dn_next;
              end
            end else begin
              if (at_stop) begin
                dir_d   = 1'b1;
                phase_d = dn_next;
              end else begin
                phase_d = up_next;
              end
            end
            strobe_d   = 1'b1;
            timer_load = 1'b1;
          end else
`endif
          if (!sweep_end) begin
            phase_d    = up_next;
            strobe_d   = 1'b1;
            timer_load = 1'b1;
          end else if (cont_q) begin
            phase_d    = start_q;
            strobe_d   = 1'b1;
            timer_load = 1'b1;
          end else begin
            state_d = StFin;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Datapath registers: phase increment, update strobe and configuration shadows.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= '0;
      strobe_q <= 1'b0;
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      cont_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      strobe_q <= strobe_d;
      if (shadow_load) begin
        start_q <= cfg_start_inc;
        stop_q  <= cfg_stop_inc;
        step_q  <= cfg_step;
        dwell_q <= cfg_dwell;
        cont_q  <= cfg_continuous;
      end
    end
  end

`ifdef NCO_SWEEP_TRIANGLE_EN
  // Sweep direction for triangle mode.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  // Outputs: busy during dwell, done for the single FIN cycle.
  always_comb begin
    phase_inc   = phase_q;
    step_strobe = strobe_q;
    busy        = (state_q == StDwell);
    done        = (state_q == StFin);
  end

endmodule
